// File: rtl/core_pkg.sv
// core_pkg: core-wide bus widths shared by the memory-side blocks.
package core_pkg;
    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
endpackage : core_pkg

// File: rtl/dmem_resp_pkg.sv
// dmem_resp_pkg: state encoding, LFSR constants and counter width for dmem_responder.
package dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam logic [7:0]  LFSR_SEED = 8'h5A;
    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from state bits 7,5,4,3
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;
    localparam int unsigned CNT_WIDTH = 5;

    // One Fibonacci step: shift left, feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage : dmem_resp_pkg

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Fibonacci LFSR used to inject random response stalls.
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, loads LFSR_SEED
//   i_en    : advance one step
//   o_state : current LFSR state (registered)
module lfsr8
    import dmem_resp_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic [7:0] o_state
);

    logic [7:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= LFSR_SEED;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule : lfsr8

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core d_m_* load/store interface.
// Services one request at a time from a word array with byte-masked writes
// and a parameterised response latency; d_m_hit_o pulses once per request.
// Optional feature macro: DMEM_RAND_STALL_EN (adds 0..3 random wait cycles).
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   d_m_addr_i    : byte address
//   d_m_rden_i    : read request
//   d_m_wren_i    : write request
//   d_m_wmask_i   : byte-lane write enables
//   d_m_wdata_i   : write data
//   d_m_rdata_o   : registered read data, valid in hit cycle, held after
//   d_m_hit_o     : one-cycle response valid
//   err_o         : out-of-range flag, only in hit cycle
module dmem_responder
    import core_pkg::*;
    import dmem_resp_pkg::*;
#(
    parameter int unsigned           Depth       = 1024,
    parameter logic [ADDR_WIDTH-1:0] BaseAddress = '0,
    parameter int unsigned           Latency     = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   d_m_addr_i,
    input  logic                    d_m_rden_i,
    input  logic                    d_m_wren_i,
    input  logic [DATA_WIDTH/8-1:0] d_m_wmask_i,
    input  logic [DATA_WIDTH-1:0]   d_m_wdata_i,
    output logic [DATA_WIDTH-1:0]   d_m_rdata_o,
    output logic                    d_m_hit_o,
    output logic                    err_o
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned OFF_BITS  = $clog2(BYTES);
    localparam int unsigned IDX_WIDTH = $clog2(Depth);

    logic [DATA_WIDTH-1:0] r_mem [Depth];

    dmem_state_e           r_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  r_oor;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_hit;
    logic                  r_err;

    logic [ADDR_WIDTH-1:0] w_rel;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDX_WIDTH-1:0]  w_idx;
    logic                  w_in_range;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [CNT_WIDTH-1:0]  w_extra;
    logic [CNT_WIDTH-1:0]  w_total;

    // Modular offset from the base; addresses below the base wrap high and fall out of range.
    assign w_rel      = d_m_addr_i - BaseAddress;
    assign w_word     = w_rel >> OFF_BITS;
    assign w_in_range = (w_word < ADDR_WIDTH'(Depth));
    assign w_idx      = w_word[IDX_WIDTH-1:0];
    assign w_accept   = !rst_i && (r_state == IDLE) && (d_m_rden_i || d_m_wren_i);

    // Post-write word: old contents with enabled lanes replaced (unchanged for pure reads).
    always_comb begin
        w_merged = r_mem[w_idx];
        for (int b = 0; b < BYTES; b++) begin
            if (d_m_wren_i && d_m_wmask_i[b]) begin
                w_merged[8*b +: 8] = d_m_wdata_i[8*b +: 8];
            end
        end
    end

`ifdef DMEM_RAND_STALL_EN
    logic [7:0] w_lfsr;

    lfsr8 u_lfsr (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_en    (w_accept),
        .o_state (w_lfsr)
    );

    // Low two bits, sampled before this acceptance advances the LFSR.
    assign w_extra = CNT_WIDTH'(w_lfsr & 8'h03);
`else
    assign w_extra = '0;
`endif

    assign w_total = CNT_WIDTH'(Latency) + w_extra;

    // Array write is committed on the acceptance edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && d_m_wren_i && w_in_range) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Request FSM with registered response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_idx <= w_idx;
                        r_oor <= !w_in_range;
                        if (w_total == CNT_WIDTH'(1)) begin
                            // Same-edge RESP entry: the array has not updated yet, so use the merged word.
                            r_state <= RESP;
                            r_hit   <= 1'b1;
                            r_err   <= !w_in_range;
                            r_rdata <= w_in_range ? w_merged : '0;
                        end else begin
                            r_state <= WAIT;
                            r_cnt   <= w_total - CNT_WIDTH'(2);
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_hit   <= 1'b1;
                        r_err   <= r_oor;
                        r_rdata <= r_oor ? '0 : r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt - CNT_WIDTH'(1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign d_m_rdata_o = r_rdata;
    assign d_m_hit_o   = r_hit;
    assign err_o       = r_err;

endmodule : dmem_responder

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder: the memory-side end of the core's `d_m_*` load/store interface. It services one request at a time from a synchronous word array, with byte-masked writes and a parameterised response latency. It asserts `d_m_hit_o` for exactly one cycle per serviced request. It sits between the core's memory stage and the simulation/FPGA top, and replaces an ideal zero-wait memory so that the core's stall paths get exercised.

## Interface
- `Depth`, 1024: number of `DATA_WIDTH`-bit words; must be a power of two.
- `BaseAddress`, `'0`: byte address that maps to word 0.
- `Latency`, 1: base cycles from request acceptance to hit; legal range 1..15.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `d_m_addr_i` in `ADDR_WIDTH`: byte address of the load/store.
- `d_m_rden_i` in 1: read request.
- `d_m_wren_i` in 1: write request.
- `d_m_wmask_i` in `DATA_WIDTH/8`: byte-lane write enables.
- `d_m_wdata_i` in `DATA_WIDTH`: write data.
- `d_m_rdata_o` out `DATA_WIDTH`: registered read data.
- `d_m_hit_o` out 1: response valid; high for exactly one cycle.
- `err_o` out 1: out-of-range access flag; high only in the hit cycle.

## Operation
- FSM states:
  - IDLE: reset state; the block samples requests only here.
  - WAIT: counting down the response delay.
  - RESP: hit cycle.
- Accept: in IDLE, on a rising edge with `d_m_rden_i | d_m_wren_i`:
  - Capture the address and read/write kind.
  - Commit the write.
  - Compute `total = Latency + extra` (`extra` = 0 unless `DMEM_RAND_STALL_EN` is defined).
  - If `total == 1`, go to RESP. Otherwise go to WAIT with `cnt = total - 2`.
- WAIT: each edge, if `cnt == 0` go to RESP, otherwise `cnt--`.
- Entering RESP loads `d_m_rdata_o` from the captured word (read or write request alike). RESP always returns to IDLE on the next edge.
- Index: `idx = (addr - BaseAddress) >> log2(DATA_WIDTH/8)`.
  - The low address bits are ignored; there is no misalignment handling.
  - The subtraction is `ADDR_WIDTH`-bit modular.
- Out of range (`idx >= Depth`, including wrap-around below `BaseAddress`):
  - No write.
  - `d_m_rdata_o` loads 0.
  - `err_o = 1` together with the hit.
- Write: lane `b` of the word is updated with `wdata[8b+7:8b]` iff `wmask[b]`. A write with an all-zero mask still hits and changes nothing.
- `rden & wren` together: the write is performed, and the read data returns the post-write word.
- Requests present during WAIT/RESP are ignored. The requester must hold its request stable until it sees the hit.

## Timing
- Reset values: state IDLE, `d_m_hit_o = 0`, `err_o = 0`, `d_m_rdata_o = 0`, `cnt = 0`.
- Array contents are not cleared by reset.
- Request first presented in IDLE cycle `c` → hit in cycle `c + Latency + extra`.
- `d_m_rdata_o` is valid in the hit cycle and holds until the next RESP entry.
- Earliest next acceptance is the edge ending cycle `c + Latency + extra + 1`. Sustained throughput is one access per `Latency + extra + 1` cycles.
- A write is visible to any request accepted after its acceptance edge.
- Reset mid-operation (WAIT or RESP): the block returns to IDLE next edge and suppresses the hit. A write already committed stays committed.

## Configuration
- `DMEM_RAND_STALL_EN` defined:
  - An 8-bit Fibonacci LFSR (taps x^8+x^6+x^5+x^4+1) resets to 0x5A and advances on each acceptance.
  - `extra = lfsr[1:0]`, sampled before the advance, giving 0..3 extra wait cycles.
- `DMEM_RAND_STALL_EN` undefined: `extra = 0`, no LFSR logic, and latency is exactly `Latency`.

## Structure
- `dmem_resp_pkg`:
  - state enum `dmem_state_e` (IDLE, WAIT, RESP);
  - `LFSR_SEED = 8'h5A`;
  - `LFSR_TAPS`;
  - `CNT_WIDTH = 5`.
- Width constants are imported from `core_pkg`.
- Sub-module `lfsr8` (enable, synchronous active-high reset, 8-bit state out), instantiated only under `DMEM_RAND_STALL_EN`.

## Test plan
- Latency=1, write 0xDEADBEEF to BaseAddress+0x10 with mask all-ones, then read it back:
  - hit one cycle after each request;
  - `rdata = 0xDEADBEEF`;
  - `err_o = 0`.
- Latency=4, read with `rden` held:
  - hit exactly 4 cycles after first presentation, high for 1 cycle;
  - next request accepted no earlier than 5 cycles after the first.
- Word 0x11223344 (DATA_WIDTH=32), write 0xAABBCCDD with mask 4'b0101 → readback 0x11BB33DD.
- Read at BaseAddress + 4·Depth, and at BaseAddress − 4:
  - `rdata = 0`;
  - `err_o = 1` in the hit cycle;
  - array unchanged.
- Latency=3, assert `rst_i` during WAIT:
  - no hit;
  - outputs return to 0 next cycle;
  - the committed write is still readable.
- `DMEM_RAND_STALL_EN`, Latency=1, 16 back-to-back reads:
  - each hit delay equals `1 + lfsr[1:0]`, matching the reference LFSR sequence from seed 0x5A.
